// File: rtl/nasti_arb_ctrl_if.sv
// Request/grant bundle between NASTI ports and the arbiter control block.
// The master side raises requests and strobes; the slave side is the arbiter.
interface nasti_arb_ctrl_if #(
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          enable_i;
    logic [N-1:0]  req_i;
    logic          hs_i;
    logic          release_i;
    logic          done_valid_i;
    logic [IW-1:0] done_port_i;

    logic [N-1:0]  gnt_o;
    logic [IW-1:0] sel_o;
    logic          gnt_valid_o;
    logic          locked_o;
    logic [3:0]    total_o;
    logic          full_o;
    logic          err_o;

    modport master (
        output enable_i, req_i, hs_i, release_i,
        output done_valid_i, done_port_i,
        input  gnt_o, sel_o, gnt_valid_o, locked_o,
        input  total_o, full_o, err_o
    );

    modport slave (
        input  enable_i, req_i, hs_i, release_i,
        input  done_valid_i, done_port_i,
        output gnt_o, sel_o, gnt_valid_o, locked_o,
        output total_o, full_o, err_o
    );
endinterface

// File: rtl/nasti_arb_ctrl.sv
// Round-robin NASTI request arbiter with per-port and global
// outstanding-transaction limits and optional grant locking.
module nasti_arb_ctrl #(
    parameter int N         = 8,
    parameter int PORT_MAX  = 2,
    parameter int TOTAL_MAX = 4,
    parameter bit LOCK      = 1'b1
) (
    input logic             clk,
    input logic             rst,
    nasti_arb_ctrl_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [2:0] PMAX = 3'(PORT_MAX);
    localparam logic [3:0] TMAX = 4'(TOTAL_MAX);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] rr_q, rr_d;
    logic          gv_q, gv_d;
    logic          lk_q, lk_d;
    logic [2:0]    cnt_q [N];
    logic [2:0]    cnt_d [N];
    logic [3:0]    total_q, total_d;
    logic          full_q, full_d;
    logic          err_q, err_d;

    logic [N-1:0]  elig;
    logic          found;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          inc;
    logic          dec_req;
    logic          dec_ok;
    logic          zero;
    logic          same;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = bus.req_i[i] && (cnt_q[i] < PMAX)
                      && (total_q < TMAX);
        end
    end

    // First eligible port at or above rr_q, wrapping past N-1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(rr_q) + k) % N);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign inc     = (state_q == GRANT) && bus.hs_i;
    assign dec_req = bus.done_valid_i;
    assign zero    = (cnt_q[bus.done_port_i] == 3'd0);
    assign dec_ok  = dec_req && !zero;
    assign same    = inc && dec_req && (bus.done_port_i == sel_q);

    // An accept and a completion on the same port cancel out.
    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
        if (!same) begin
            if (inc) begin
                cnt_d[sel_q] = cnt_q[sel_q] + 3'd1;
            end
            if (dec_ok) begin
                cnt_d[bus.done_port_i] = cnt_d[bus.done_port_i] - 3'd1;
            end
            total_d = total_q + {3'b000, inc} - {3'b000, dec_ok};
        end
        err_d  = err_q | (dec_req && zero);
        full_d = (total_d == TMAX);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        gv_d    = gv_q;
        lk_d    = lk_q;
        unique case (state_q)
            IDLE: begin
                if (bus.enable_i && found) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << pick;
                    sel_d   = pick;
                    gv_d    = 1'b1;
                end
            end
            GRANT: begin
                if (bus.hs_i) begin
                    rr_d = (sel_q == IW'(N - 1)) ? '0 : sel_q + IW'(1);
                    gv_d = 1'b0;
                    if (LOCK) begin
                        state_d = HOLD;
                        lk_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (!bus.req_i[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    gv_d    = 1'b0;
                end
            end
            HOLD: begin
                if (bus.release_i) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    lk_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            rr_q    <= '0;
            gv_q    <= 1'b0;
            lk_q    <= 1'b0;
            total_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            gv_q    <= gv_d;
            lk_q    <= lk_d;
            total_q <= total_d;
            full_q  <= full_d;
            err_q   <= err_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.sel_o       = sel_q;
    assign bus.gnt_valid_o = gv_q;
    assign bus.locked_o    = lk_q;
    assign bus.total_o     = total_q;
    assign bus.full_o      = full_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_nasti_arb_ctrl.sv
// Directed bench for nasti_arb_ctrl: cycle table on a LOCK=1 instance,
// plus rotation and LOCK=0 sequences.
module tb_nasti_arb_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nasti_arb_ctrl_if #(.N(8)) b0();
    nasti_arb_ctrl_if #(.N(8)) b1();

    nasti_arb_ctrl #(
        .N(8), .PORT_MAX(2), .TOTAL_MAX(4), .LOCK(1'b1)
    ) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );

    nasti_arb_ctrl #(
        .N(8), .PORT_MAX(2), .TOTAL_MAX(4), .LOCK(1'b0)
    ) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int rst, en, req, hs, rel, dv, dp;
        int gnt, sel, gv, lk, tot, full, err;
    } vec_t;

    localparam int NV = 41;
    vec_t tv[NV];

    function automatic vec_t mk(input int r, e, q, h, l, d, p,
                                input int g, s, gv, lk, t, f, er);
        vec_t v;
        v.rst = r; v.en = e; v.req = q; v.hs = h;
        v.rel = l; v.dv = d; v.dp = p;
        v.gnt = g; v.sel = s; v.gv = gv; v.lk = lk;
        v.tot = t; v.full = f; v.err = er;
        return v;
    endfunction

    function automatic logic [18:0] pk(input int g, s, gv, lk, t, f, er);
        return {8'(g), 3'(s), 1'(gv), 1'(lk), 4'(t), 1'(f), 1'(er)};
    endfunction

    function automatic logic [18:0] got0();
        return {b0.gnt_o, b0.sel_o, b0.gnt_valid_o, b0.locked_o,
                b0.total_o, b0.full_o, b0.err_o};
    endfunction

    function automatic logic [18:0] got1();
        return {b1.gnt_o, b1.sel_o, b1.gnt_valid_o, b1.locked_o,
                b1.total_o, b1.full_o, b1.err_o};
    endfunction

    task automatic drv0(input int e, q, h, l, d, p);
        b0.enable_i     = 1'(e);
        b0.req_i        = 8'(q);
        b0.hs_i         = 1'(h);
        b0.release_i    = 1'(l);
        b0.done_valid_i = 1'(d);
        b0.done_port_i  = 3'(p);
    endtask

    task automatic drv1(input int e, q, h, l, d, p);
        b1.enable_i     = 1'(e);
        b1.req_i        = 8'(q);
        b1.hs_i         = 1'(h);
        b1.release_i    = 1'(l);
        b1.done_valid_i = 1'(d);
        b1.done_port_i  = 3'(p);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [18:0] got, exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got gnt=%h sel=%0d gv=%b lk=%b tot=%0d full=%b err=%b; want gnt=%h sel=%0d gv=%b lk=%b tot=%0d full=%b err=%b",
                     nm, got[18:11], got[10:8], got[7], got[6], got[5:2], got[1], got[0],
                     exp[18:11], exp[10:8], exp[7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        //            rst en req  hs rl dv dp   gnt  sel gv lk tot fu er
        tv[0]  = mk(1, 0, 'h00, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, 'h06, 0, 0, 0, 0, 'h02, 1, 1, 0, 0, 0, 0);
        tv[2]  = mk(0, 1, 'h06, 1, 0, 0, 0, 'h02, 1, 0, 1, 1, 0, 0);
        tv[3]  = mk(0, 1, 'h06, 0, 1, 0, 0, 'h00, 1, 0, 0, 1, 0, 0);
        tv[4]  = mk(0, 1, 'h06, 0, 0, 0, 0, 'h04, 2, 1, 0, 1, 0, 0);
        tv[5]  = mk(0, 1, 'h02, 0, 0, 0, 0, 'h00, 2, 0, 0, 1, 0, 0);
        tv[6]  = mk(0, 1, 'h06, 0, 0, 0, 0, 'h04, 2, 1, 0, 1, 0, 0);
        tv[7]  = mk(0, 0, 'h06, 0, 0, 0, 0, 'h04, 2, 1, 0, 1, 0, 0);
        tv[8]  = mk(0, 0, 'h06, 1, 0, 1, 1, 'h04, 2, 0, 1, 1, 0, 0);
        tv[9]  = mk(0, 0, 'h06, 1, 0, 0, 0, 'h04, 2, 0, 1, 1, 0, 0);
        tv[10] = mk(0, 0, 'h06, 0, 1, 0, 0, 'h00, 2, 0, 0, 1, 0, 0);
        tv[11] = mk(0, 0, 'h06, 0, 0, 0, 0, 'h00, 2, 0, 0, 1, 0, 0);
        tv[12] = mk(0, 0, 'h06, 0, 1, 0, 0, 'h00, 2, 0, 0, 1, 0, 0);
        tv[13] = mk(0, 0, 'h00, 0, 0, 1, 6, 'h00, 2, 0, 0, 1, 0, 1);
        tv[14] = mk(0, 0, 'h00, 0, 0, 1, 2, 'h00, 2, 0, 0, 0, 0, 1);
        tv[15] = mk(0, 1, 'h08, 0, 0, 0, 0, 'h08, 3, 1, 0, 0, 0, 1);
        tv[16] = mk(0, 1, 'h08, 1, 0, 0, 0, 'h08, 3, 0, 1, 1, 0, 1);
        tv[17] = mk(0, 1, 'h08, 0, 1, 0, 0, 'h00, 3, 0, 0, 1, 0, 1);
        tv[18] = mk(0, 1, 'h08, 0, 0, 0, 0, 'h08, 3, 1, 0, 1, 0, 1);
        tv[19] = mk(0, 1, 'h08, 1, 0, 0, 0, 'h08, 3, 0, 1, 2, 0, 1);
        tv[20] = mk(0, 1, 'h08, 0, 1, 0, 0, 'h00, 3, 0, 0, 2, 0, 1);
        tv[21] = mk(0, 1, 'h28, 0, 0, 0, 0, 'h20, 5, 1, 0, 2, 0, 1);
        tv[22] = mk(0, 1, 'h28, 1, 0, 0, 0, 'h20, 5, 0, 1, 3, 0, 1);
        tv[23] = mk(0, 1, 'h08, 0, 1, 0, 0, 'h00, 5, 0, 0, 3, 0, 1);
        tv[24] = mk(0, 1, 'h08, 0, 0, 1, 3, 'h00, 5, 0, 0, 2, 0, 1);
        tv[25] = mk(0, 1, 'h08, 0, 0, 0, 0, 'h08, 3, 1, 0, 2, 0, 1);
        tv[26] = mk(0, 1, 'h08, 1, 0, 1, 3, 'h08, 3, 0, 1, 2, 0, 1);
        tv[27] = mk(0, 1, 'h00, 0, 1, 0, 0, 'h00, 3, 0, 0, 2, 0, 1);
        tv[28] = mk(0, 1, 'h01, 0, 0, 0, 0, 'h01, 0, 1, 0, 2, 0, 1);
        tv[29] = mk(0, 1, 'h01, 1, 0, 0, 0, 'h01, 0, 0, 1, 3, 0, 1);
        tv[30] = mk(0, 1, 'h00, 0, 1, 0, 0, 'h00, 0, 0, 0, 3, 0, 1);
        tv[31] = mk(0, 1, 'h02, 0, 0, 0, 0, 'h02, 1, 1, 0, 3, 0, 1);
        tv[32] = mk(0, 1, 'h02, 1, 0, 0, 0, 'h02, 1, 0, 1, 4, 1, 1);
        tv[33] = mk(0, 1, 'hFF, 0, 1, 0, 0, 'h00, 1, 0, 0, 4, 1, 1);
        tv[34] = mk(0, 1, 'hFF, 0, 0, 0, 0, 'h00, 1, 0, 0, 4, 1, 1);
        tv[35] = mk(0, 1, 'hFF, 0, 0, 1, 5, 'h00, 1, 0, 0, 3, 0, 1);
        tv[36] = mk(0, 1, 'hFF, 0, 0, 0, 0, 'h04, 2, 1, 0, 3, 0, 1);
        tv[37] = mk(0, 1, 'hFF, 1, 0, 0, 0, 'h04, 2, 0, 1, 4, 1, 1);
        tv[38] = mk(1, 1, 'hFF, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0, 0);
        tv[39] = mk(0, 1, 'h01, 0, 0, 0, 0, 'h01, 0, 1, 0, 0, 0, 0);
        tv[40] = mk(0, 1, 'h00, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0, 0);

        drv0(0, 0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = 1'(tv[i].rst);
            drv0(tv[i].en, tv[i].req, tv[i].hs, tv[i].rel,
                 tv[i].dv, tv[i].dp);
            cyc();
            chk($sformatf("vec%0d", i), got0(),
                pk(tv[i].gnt, tv[i].sel, tv[i].gv, tv[i].lk,
                   tv[i].tot, tv[i].full, tv[i].err));
        end

        // Full rotation with immediate completions, wrapping to port 0.
        for (int i = 0; i < 9; i++) begin
            int p;
            p = i % 8;
            @(negedge clk);
            drv0(1, 'hFF, 0, 0, 0, 0);
            cyc();
            chk($sformatf("rot%0d_grant", i), got0(),
                pk(1 << p, p, 1, 0, 0, 0, 0));
            @(negedge clk);
            drv0(1, 'hFF, 1, 0, 0, 0);
            cyc();
            chk($sformatf("rot%0d_hold", i), got0(),
                pk(1 << p, p, 0, 1, 1, 0, 0));
            @(negedge clk);
            drv0(1, 'hFF, 0, 1, 1, p);
            cyc();
            chk($sformatf("rot%0d_rel", i), got0(),
                pk(0, p, 0, 0, 0, 0, 0));
        end

        // Unlocked instance: handshake returns straight to IDLE.
        @(negedge clk);
        rst = 1'b1;
        drv0(0, 0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0, 0);
        cyc();
        chk("l0_rst", got1(), pk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        drv1(1, 'h01, 0, 0, 0, 0);
        cyc();
        chk("l0_grant", got1(), pk('h01, 0, 1, 0, 0, 0, 0));
        @(negedge clk);
        drv1(1, 'h01, 1, 0, 0, 0);
        cyc();
        chk("l0_hs_idle", got1(), pk(0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        drv1(1, 'h01, 0, 0, 0, 0);
        cyc();
        chk("l0_regrant", got1(), pk('h01, 0, 1, 0, 1, 0, 0));
        @(negedge clk);
        drv1(1, 'h01, 1, 1, 0, 0);
        cyc();
        chk("l0_hs2", got1(), pk(0, 0, 0, 0, 2, 0, 0));
        @(negedge clk);
        drv1(1, 'h01, 0, 0, 0, 0);
        cyc();
        chk("l0_port_max", got1(), pk(0, 0, 0, 0, 2, 0, 0));
        @(negedge clk);
        drv1(1, 'h01, 0, 0, 1, 0);
        cyc();
        chk("l0_done", got1(), pk(0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        drv1(1, 'h01, 0, 0, 0, 0);
        cyc();
        chk("l0_eligible", got1(), pk('h01, 0, 1, 0, 1, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
